// File: rtl/alu_exec_seq.sv
// Execute sequencer around an external combinational 8-bit ALU: one instruction
// in flight, register file, C/Z flags, a direct load port and a debug read port.
module alu_exec_seq #(
    parameter int NUM_REGS   = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [REG_ADDR_W-1:0] req_dst,
    input  logic [REG_ADDR_W-1:0] req_src,

    input  logic                  ld_en,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [7:0]            ld_data,

    output logic [2:0]            alu_operation,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    input  logic [7:0]            alu_c,
    input  logic                  alu_c_flag,
    input  logic                  alu_z_flag,

    output logic                  done,
    output logic                  err,
    output logic                  flag_c,
    output logic                  flag_z,

    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [7:0]            dbg_data
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [7:0]            regs [NUM_REGS];
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [REG_ADDR_W-1:0] src_q;
    logic [7:0]            a_q;
    logic [7:0]            b_q;
    logic [2:0]            alu_op_q;
    logic [7:0]            res_q;
    logic                  res_c_q;
    logic                  res_z_q;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    endfunction

    // Out-of-range indices (non power-of-two NUM_REGS) read as zero.
    function automatic logic [7:0] reg_rd(input logic [REG_ADDR_W-1:0] addr);
        logic [7:0] val;
        val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == REG_ADDR_W'(i)) val = regs[i];
        end
        return val;
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next-state defaults to the current state before the case, so no
    // path through this block can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid) state_next = op_legal(req_op) ? READ : ERR;
            READ:    state_next = EXEC;
            EXEC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign done      = (state == WRITE) || (state == ERR);
    assign err       = (state == ERR);

    // Instruction, operand and result latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 3'd0;
            dst_q    <= '0;
            src_q    <= '0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            alu_op_q <= 3'd0;
            res_q    <= 8'h00;
            res_c_q  <= 1'b0;
            res_z_q  <= 1'b0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        dst_q <= req_dst;
                        src_q <= req_src;
                    end
                end
                READ: begin
                    a_q      <= reg_rd(dst_q);
                    b_q      <= reg_rd(src_q);
                    alu_op_q <= op_q;
                end
                EXEC: begin
                    res_q   <= alu_c;
                    res_c_q <= alu_c_flag;
                    res_z_q <= alu_z_flag;
                end
                WRITE: begin
                    flag_c <= res_c_q;
                    flag_z <= res_z_q;
                end
                default: ;
            endcase
        end
    end

    // The ALU sees the operand latches directly; they only change at the
    // READ->EXEC edge, so the inputs are stable through EXEC and hold after.
    assign alu_operation = alu_op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;

    // NOTE: the register file is reset here because an abandoned or fresh
    // instruction must never see stale contents; this rules out a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (state == WRITE && dst_q == REG_ADDR_W'(i))
                    regs[i] <= res_q;
                else if (state == IDLE && ld_en && ld_addr == REG_ADDR_W'(i))
                    regs[i] <= ld_data;
            end
        end
    end

    assign dbg_data = reg_rd(dbg_addr);

endmodule
